// File: rtl/video_stream_sink_checker.sv
// video_stream_sink_checker: Avalon-ST 24-bit RGB video sink that checks frame geometry and checksums frames
// Ports:
//   i_clk, i_reset_n          clock, asynchronous active-low reset
//   i_s_cs/read/write         8-bit register slave, read latency 1
//   i_s_address, i_s_writedata, o_s_readdata
//   o_snk_ready               registered copy of CTRL.enable (ready latency 1)
//   i_snk_valid/data/sop/eop  video stream in; data is a header or a {B,G,R} pixel
module video_stream_sink_checker #(
    parameter int VIDEO_W = 800,
    parameter int VIDEO_H = 600
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_s_cs,
    input  logic        i_s_read,
    input  logic        i_s_write,
    input  logic [2:0]  i_s_address,
    input  logic [7:0]  i_s_writedata,
    output logic [7:0]  o_s_readdata,
    output logic        o_snk_ready,
    input  logic        i_snk_valid,
    input  logic [23:0] i_snk_data,
    input  logic        i_snk_sop,
    input  logic        i_snk_eop
);
    typedef enum logic [1:0] {IDLE, VIDEO, SKIP} state_t;
    state_t      r_state;
    logic [15:0] r_x, r_y, r_cksum, r_frame_cnt, r_frame_cksum;
    logic [7:0]  r_err_cnt;
    logic [3:0]  r_hdr;
    logic        r_enable, r_in_frame, r_last_ok, r_size_err, r_sop_err;
    logic [15:0] w_cksum_next;
    logic [7:0]  w_rd_mux, w_err_inc;
    logic        w_last_pix, w_x_wrap, w_wr, w_rd, w_clr;
    always_comb begin
        w_cksum_next = r_cksum + 16'(i_snk_data[7:0]) + 16'(i_snk_data[15:8]) + 16'(i_snk_data[23:16]);
        w_x_wrap     = r_x == 16'(VIDEO_W - 1);
        w_last_pix   = w_x_wrap && r_y == 16'(VIDEO_H - 1);
        w_wr         = i_s_cs & i_s_write;
        // a write in the same cycle as a read suppresses the read
        w_rd         = i_s_cs & i_s_read & ~w_wr;
        w_clr        = w_wr && i_s_address == 3'd0 && i_s_writedata[1];
        w_err_inc    = r_err_cnt + {7'd0, r_err_cnt != 8'hFF};
        w_rd_mux     = i_s_address == 3'd0 ? {7'd0, r_enable} :
                       i_s_address == 3'd1 ? {4'd0, r_sop_err, r_size_err, r_last_ok, r_in_frame} :
                       i_s_address == 3'd2 ? r_frame_cnt[7:0] :
                       i_s_address == 3'd3 ? r_frame_cnt[15:8] :
                       i_s_address == 3'd4 ? r_err_cnt :
                       i_s_address == 3'd5 ? r_frame_cksum[7:0] :
                       i_s_address == 3'd6 ? r_frame_cksum[15:8] : {4'd0, r_hdr};
    end
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= IDLE;
            r_x           <= '0;
            r_y           <= '0;
            r_cksum       <= '0;
            r_frame_cnt   <= '0;
            r_frame_cksum <= '0;
            r_err_cnt     <= '0;
            r_hdr         <= '0;
            r_enable      <= 1'b1;
            r_in_frame    <= 1'b0;
            r_last_ok     <= 1'b0;
            r_size_err    <= 1'b0;
            r_sop_err     <= 1'b0;
            o_s_readdata  <= '0;
            o_snk_ready   <= 1'b0;
        end else begin
            o_snk_ready <= r_enable;
            if (w_rd) o_s_readdata <= w_rd_mux;
            if (w_wr && i_s_address == 3'd0) r_enable <= i_s_writedata[0];
            if (i_snk_valid) begin
                if (i_snk_sop) begin
                    // a sop inside a video frame is an error, then parsed as a fresh header
                    if (r_state == VIDEO) begin
                        r_sop_err <= 1'b1;
                        r_err_cnt <= w_err_inc;
                        r_last_ok <= 1'b0;
                    end
                    r_hdr      <= i_snk_data[3:0];
                    r_x        <= '0;
                    r_y        <= '0;
                    r_cksum    <= '0;
                    r_in_frame <= i_snk_data[3:0] == 4'd0 && !i_snk_eop;
                    r_state    <= i_snk_eop ? IDLE : i_snk_data[3:0] == 4'd0 ? VIDEO : SKIP;
                end else if (r_state == VIDEO) begin
                    r_cksum <= w_cksum_next;
                    if (i_snk_eop || w_last_pix) begin
                        // overflow (last pixel without eop) drains the rest of the packet in SKIP
                        r_in_frame <= 1'b0;
                        r_state    <= i_snk_eop ? IDLE : SKIP;
                        r_last_ok  <= i_snk_eop && w_last_pix;
                        if (i_snk_eop) r_frame_cksum <= w_cksum_next;
                        if (i_snk_eop && w_last_pix) r_frame_cnt <= r_frame_cnt + 16'd1;
                        else begin
                            r_size_err <= 1'b1;
                            r_err_cnt  <= w_err_inc;
                        end
                    end else begin
                        r_x <= w_x_wrap ? 16'd0 : r_x + 16'd1;
                        r_y <= w_x_wrap ? r_y + 16'd1 : r_y;
                    end
                end else if (r_state == SKIP && i_snk_eop) r_state <= IDLE;
            end
            // clear overrides any same-cycle counter or flag update
            if (w_clr) begin
                r_frame_cnt <= '0;
                r_err_cnt   <= '0;
                r_size_err  <= 1'b0;
                r_sop_err   <= 1'b0;
                r_last_ok   <= 1'b0;
            end
        end
    end
endmodule
